// File: rtl/dlx_decode_issue.sv
// DLX decode/issue stage: decodes instructions, reads the register file, tracks
// pending writes to stall on read-after-write hazards, and registers ALU operands.
module dlx_decode_issue #(
   parameter int REGISTER_WIDTH  = 32,
   parameter int IMMEDIATE_WIDTH = 16,
   parameter int REG_ADDR_WIDTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [31:0]               in_instr,
   output logic                      in_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [REGISTER_WIDTH-1:0] aluin1,
   output logic [REGISTER_WIDTH-1:0] aluin2,
   output logic [2:0]                opselect,
   output logic [2:0]                operation,
   output logic [4:0]                shift_amt,
   output logic                      enable_arith,
   output logic                      enable_shift,
   output logic [REG_ADDR_WIDTH-1:0] dest,
   input  logic                      wb_en,
   input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
   input  logic [REGISTER_WIDTH-1:0] wb_data,
   input  logic                      flush,
   output logic                      illegal_instr
);

   localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

   typedef enum logic [2:0] {
      OP_SHIFT_REG = 3'b000,
      OP_ARITH     = 3'b001,
      OP_SHIFT_IMM = 3'b010,
      OP_MEM_WRITE = 3'b100,
      OP_MEM_READ  = 3'b101
   } opsel_e;

   logic [REGISTER_WIDTH-1:0]  regs [NUM_REGS];
   logic [NUM_REGS-1:0]        pending;

   logic [2:0]                 f_opsel;
   logic [2:0]                 f_oper;
   logic                       f_imm_sel;
   logic [REG_ADDR_WIDTH-1:0]  f_dest;
   logic [REG_ADDR_WIDTH-1:0]  f_src1;
   logic                       f_imm_sign;
   logic [REG_ADDR_WIDTH-1:0]  f_src2;
   logic [IMMEDIATE_WIDTH-1:0] f_imm;

   assign f_opsel    = in_instr[31:29];
   assign f_oper     = in_instr[28:26];
   assign f_imm_sel  = in_instr[25];
   assign f_dest     = in_instr[24:21];
   assign f_src1     = in_instr[20:17];
   assign f_imm_sign = in_instr[16];
   assign f_src2     = in_instr[15:12];
   assign f_imm      = in_instr[15:0];

   logic [REGISTER_WIDTH-1:0] src1_val;
   logic [REGISTER_WIDTH-1:0] src2_val;
   logic [REGISTER_WIDTH-1:0] imm_ext;
   logic [REGISTER_WIDTH-1:0] op2_val;
   logic [4:0]                shamt;
   logic                      legal;
   logic                      is_shift;
   logic                      is_store;
   logic                      writes_dest;
   logic [NUM_REGS-1:0]       wb_clear;
   logic [NUM_REGS-1:0]       set_mask;
   logic [NUM_REGS-1:0]       pend_eff;
   logic                      hazard;
   logic                      accept;

   // Register 0 is hardwired to zero; a same-cycle writeback is forwarded to the read.
   always_comb begin
      src1_val = regs[f_src1];
      src2_val = regs[f_src2];
      if (wb_en && wb_addr == f_src1) src1_val = wb_data;
      if (wb_en && wb_addr == f_src2) src2_val = wb_data;
      if (f_src1 == '0) src1_val = '0;
      if (f_src2 == '0) src2_val = '0;
   end

   assign imm_ext = f_imm_sign ? {{(REGISTER_WIDTH-IMMEDIATE_WIDTH){f_imm[IMMEDIATE_WIDTH-1]}}, f_imm}
                               : {{(REGISTER_WIDTH-IMMEDIATE_WIDTH){1'b0}}, f_imm};
   assign op2_val = f_imm_sel ? imm_ext : src2_val;

   // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
   always_comb begin
      legal    = 1'b0;
      is_shift = 1'b0;
      is_store = 1'b0;
      shamt    = 5'd0;
      case (f_opsel)
         OP_SHIFT_REG: begin legal = 1'b1; is_shift = 1'b1; shamt = src2_val[4:0]; end
         OP_SHIFT_IMM: begin legal = 1'b1; is_shift = 1'b1; shamt = f_imm[4:0];    end
         OP_ARITH:     legal = 1'b1;
         OP_MEM_READ:  legal = 1'b1;
         OP_MEM_WRITE: begin legal = 1'b1; is_store = 1'b1; end
         default:      legal = 1'b0;
      endcase
   end

   assign writes_dest = legal && !is_store && (f_dest != '0);

   // A writeback this cycle already satisfies any reader of that register.
   assign wb_clear = wb_en ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << wb_addr) : '0;
   assign pend_eff = pending & ~wb_clear;

   assign hazard   = in_valid && (pend_eff[f_src1] ||
                                  (!f_imm_sel && pend_eff[f_src2]) ||
                                  (is_store && pend_eff[f_dest]));
   assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
   assign accept   = in_valid && in_ready;
   assign set_mask = (accept && writes_dest) ? ({{(NUM_REGS-1){1'b1}} & '0} | ({{(NUM_REGS-1){1'b0}}, 1'b1} << f_dest))
                                             : '0;

   // NOTE: the register file sits in the reset domain so every register reads zero after
   // reset; this forces it into flops instead of a RAM macro.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         pending       <= '0;
         out_valid     <= 1'b0;
         aluin1        <= '0;
         aluin2        <= '0;
         opselect      <= 3'd0;
         operation     <= 3'd0;
         shift_amt     <= 5'd0;
         enable_arith  <= 1'b0;
         enable_shift  <= 1'b0;
         dest          <= '0;
         illegal_instr <= 1'b0;
      end else begin
         if (wb_en && wb_addr != '0) regs[wb_addr] <= wb_data;

         // Set wins over a same-cycle writeback clear; flush wipes everything.
         pending       <= flush ? '0 : ((pending & ~wb_clear) | set_mask);
         illegal_instr <= accept && !legal;

         if (flush) begin
            out_valid <= 1'b0;
         end else if (accept && legal) begin
            out_valid    <= 1'b1;
            aluin1       <= src1_val;
            aluin2       <= op2_val;
            opselect     <= f_opsel;
            operation    <= f_oper;
            shift_amt    <= shamt;
            enable_shift <= is_shift;
            enable_arith <= !is_shift;
            dest         <= f_dest;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dlx_decode_issue.sv
// Scoreboard bench for dlx_decode_issue: stimulus pushes expected issues, a
// negedge monitor pops and compares on every consumed output.
module tb_dlx_decode_issue;

   typedef struct packed {
      logic [31:0] a1;
      logic [31:0] a2;
      logic [2:0]  os;
      logic [2:0]  op;
      logic [4:0]  sh;
      logic        ea;
      logic        es;
      logic [3:0]  dest;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_instr;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] aluin1;
   logic [31:0] aluin2;
   logic [2:0]  opselect;
   logic [2:0]  operation;
   logic [4:0]  shift_amt;
   logic        enable_arith;
   logic        enable_shift;
   logic [3:0]  dest;
   logic        wb_en;
   logic [3:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   logic        illegal_instr;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   exp_t drop_e;

   dlx_decode_issue dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .aluin1(aluin1), .aluin2(aluin2),
      .opselect(opselect), .operation(operation), .shift_amt(shift_amt),
      .enable_arith(enable_arith), .enable_shift(enable_shift), .dest(dest),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
      .illegal_instr(illegal_instr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [2:0] os, input logic [2:0] op, input logic isel,
                                      input logic [3:0] d, input logic [3:0] s1, input logic sgn,
                                      input logic [15:0] imm);
      return {os, op, isel, d, s1, sgn, imm};
   endfunction

   function automatic exp_t ex(input logic [31:0] a1, input logic [31:0] a2, input logic [2:0] os,
                               input logic [2:0] op, input logic [4:0] sh, input logic ea,
                               input logic es, input logic [3:0] d);
      exp_t e;
      e.a1 = a1; e.a2 = a2; e.os = os; e.op = op; e.sh = sh; e.ea = ea; e.es = es; e.dest = d;
      return e;
   endfunction

   // Monitor: every consumed issue must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_issue", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("aluin1", aluin1, mon_e.a1);
            check("aluin2", aluin2, mon_e.a2);
            check("opselect", 32'(opselect), 32'(mon_e.os));
            check("operation", 32'(operation), 32'(mon_e.op));
            check("shift_amt", 32'(shift_amt), 32'(mon_e.sh));
            check("enable_arith", 32'(enable_arith), 32'(mon_e.ea));
            check("enable_shift", 32'(enable_shift), 32'(mon_e.es));
            check("dest", 32'(dest), 32'(mon_e.dest));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
      wb_en = 1'b1; wb_addr = a; wb_data = d;
      tick();
      wb_en = 1'b0;
   endtask

   task automatic issue(input string name, input logic [31:0] instr, input exp_t e, input bit no_stall);
      int n;
      in_valid = 1'b1;
      in_instr = instr;
      #1;
      if (no_stall) check({name, "_ready"}, 32'(in_ready), 32'd1);
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         check({name, "_timeout"}, 32'd0, 32'd1);
      end else begin
         exp_q.push_back(e);
      end
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
      tick(); tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_aluin1", aluin1, 32'd0);
      check("rst_illegal", 32'(illegal_instr), 32'd0);
      rst = 1'b0;
      tick();
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // Test 1: sign-extended immediate add
      wb_write(4'd3, 32'h0000_0005);
      issue("add_imm", mk(3'b001, 3'b000, 1'b1, 4'd0, 4'd3, 1'b1, 16'hFFFE),
            ex(32'd5, 32'hFFFF_FFFE, 3'b001, 3'b000, 5'd0, 1'b1, 1'b0, 4'd0), 1'b1);

      // Test 2: shift-immediate sets pending[4]; reader stalls until writeback bypass
      issue("shift_imm", mk(3'b010, 3'b001, 1'b1, 4'd4, 4'd0, 1'b0, 16'h0023),
            ex(32'd0, 32'h23, 3'b010, 3'b001, 5'd3, 1'b0, 1'b1, 4'd4), 1'b1);
      in_valid = 1'b1;
      in_instr = mk(3'b001, 3'b010, 1'b1, 4'd0, 4'd4, 1'b0, 16'h0010);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("raw_stall", 32'(in_ready), 32'd0);
         tick();
      end
      wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'hAB;
      #1;
      check("raw_release", 32'(in_ready), 32'd1);
      exp_q.push_back(ex(32'hAB, 32'h10, 3'b001, 3'b010, 5'd0, 1'b1, 1'b0, 4'd0));
      tick();
      wb_en = 1'b0; in_valid = 1'b0;

      // Test 3: backpressure hold, then back-to-back issue
      issue("hold_a", mk(3'b001, 3'b011, 1'b0, 4'd5, 4'd3, 1'b0, 16'h4000),
            ex(32'd5, 32'hAB, 3'b001, 3'b011, 5'd0, 1'b1, 1'b0, 4'd5), 1'b1);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = mk(3'b101, 3'b000, 1'b1, 4'd6, 4'd4, 1'b0, 16'h0008);
      #1;
      for (int i = 0; i < 3; i++) begin
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_aluin1", aluin1, 32'd5);
         check("hold_aluin2", aluin2, 32'hAB);
         check("hold_dest", 32'(dest), 32'd5);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("b2b_ready", 32'(in_ready), 32'd1);
      exp_q.push_back(ex(32'hAB, 32'd8, 3'b101, 3'b000, 5'd0, 1'b1, 1'b0, 4'd6));
      tick();
      in_valid = 1'b0;
      check("b2b_no_bubble", 32'(out_valid), 32'd1);

      // Test 4: illegal opselect is dropped with a one-cycle pulse, no scoreboard change
      in_valid = 1'b1;
      in_instr = mk(3'b011, 3'b000, 1'b1, 4'd7, 4'd0, 1'b0, 16'h0000);
      #1;
      check("illegal_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("illegal_pulse", 32'(illegal_instr), 32'd1);
      check("illegal_no_valid", 32'(out_valid), 32'd0);
      tick();
      check("illegal_pulse_end", 32'(illegal_instr), 32'd0);
      issue("read_r7", mk(3'b001, 3'b100, 1'b1, 4'd0, 4'd7, 1'b0, 16'h0001),
            ex(32'd0, 32'd1, 3'b001, 3'b100, 5'd0, 1'b1, 1'b0, 4'd0), 1'b1);

      // Test 5: flush drops held op and clears pending[5]; writeback still lands
      issue("flushed_op", mk(3'b001, 3'b000, 1'b1, 4'd0, 4'd3, 1'b0, 16'h0002),
            ex(32'd5, 32'd2, 3'b001, 3'b000, 5'd0, 1'b1, 1'b0, 4'd0), 1'b1);
      out_ready = 1'b0;
      flush = 1'b1; wb_en = 1'b1; wb_addr = 4'd9; wb_data = 32'h99;
      #1;
      check("flush_in_ready", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0; wb_en = 1'b0;
      drop_e = exp_q.pop_back();
      check("flush_out_valid", 32'(out_valid), 32'd0);
      out_ready = 1'b1;
      issue("read_r5", mk(3'b001, 3'b001, 1'b0, 4'd0, 4'd5, 1'b0, 16'h9000),
            ex(32'd0, 32'h99, 3'b001, 3'b001, 5'd0, 1'b1, 1'b0, 4'd0), 1'b1);

      // Shift-by-register, then a store that stalls on its data register r8
      issue("shift_reg", mk(3'b000, 3'b001, 1'b0, 4'd8, 4'd3, 1'b0, 16'h4000),
            ex(32'd5, 32'hAB, 3'b000, 3'b001, 5'h0B, 1'b0, 1'b1, 4'd8), 1'b1);
      in_valid = 1'b1;
      in_instr = mk(3'b100, 3'b000, 1'b1, 4'd8, 4'd3, 1'b1, 16'h8004);
      #1;
      check("store_stall", 32'(in_ready), 32'd0);
      tick();
      wb_en = 1'b1; wb_addr = 4'd8; wb_data = 32'h77;
      #1;
      check("store_release", 32'(in_ready), 32'd1);
      exp_q.push_back(ex(32'd5, 32'hFFFF_8004, 3'b100, 3'b000, 5'd0, 1'b1, 1'b0, 4'd8));
      tick();
      wb_en = 1'b0; in_valid = 1'b0;
      issue("read_r8", mk(3'b001, 3'b000, 1'b0, 4'd0, 4'd8, 1'b0, 16'h0000),
            ex(32'h77, 32'd0, 3'b001, 3'b000, 5'd0, 1'b1, 1'b0, 4'd0), 1'b1);

      // Test 6: asynchronous reset while holding an op; r0 stays zero
      issue("reset_victim", mk(3'b001, 3'b000, 1'b1, 4'd0, 4'd3, 1'b0, 16'h0001),
            ex(32'd5, 32'd1, 3'b001, 3'b000, 5'd0, 1'b1, 1'b0, 4'd0), 1'b1);
      out_ready = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_aluin1", aluin1, 32'd0);
      check("arst_aluin2", aluin2, 32'd0);
      check("arst_enable_arith", 32'(enable_arith), 32'd0);
      check("arst_opselect", 32'(opselect), 32'd0);
      drop_e = exp_q.pop_back();
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      wb_write(4'd0, 32'h1234);
      wb_en = 1'b1; wb_addr = 4'd0; wb_data = 32'h1234;
      issue("read_r0", mk(3'b001, 3'b000, 1'b0, 4'd0, 4'd0, 1'b0, 16'h3000),
            ex(32'd0, 32'd0, 3'b001, 3'b000, 5'd0, 1'b1, 1'b0, 4'd0), 1'b1);
      wb_en = 1'b0;

      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
